// File: rtl/stream_sink_pkg.sv
// stream_sink_pkg: shared FSM states and pointer-width helper for the stream sync sink.
package stream_sink_pkg;

    typedef enum logic [2:0] {IDLE, CAPTURE, WAIT_SPACE, FREE, WAIT_LOW} state_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/stream_sync_sink_fifo.sv
// sync_fifo: power-of-two FIFO with wrap-bit pointers and a registered head/valid output.
module sync_fifo
    import stream_sink_pkg::*;
#(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  valid,
    output logic                  full,
    output logic                  empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr, rd_nxt;

    assign level  = wr_ptr - rd_ptr;
    assign empty  = wr_ptr == rd_ptr;
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_nxt = rd_ptr + PW'(pop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    // Head/valid look only at entries stored before this edge, so a write shows up one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            valid  <= 1'b0;
            rdata  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_nxt;
            valid  <= wr_ptr != rd_nxt;
            if (wr_ptr != rd_nxt) rdata <= mem[rd_nxt[AW-1:0]];
        end
    end

endmodule

// File: rtl/stream_sync_sink.sv
// stream_sync_sink: synchronises merge drive events, stores the word in a FIFO, then returns free.
// Define STREAM_SYNC_SINK_STATS_EN to add the o_tokens and o_stall_cycles counters.
module stream_sync_sink
    import stream_sink_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FREE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_drive,
    output logic                   o_free,
    input  logic [DATA_WIDTH-1:0]  i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [DATA_WIDTH-1:0]  o_data,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_busy
`ifdef STREAM_SYNC_SINK_STATS_EN
    ,
    output logic [31:0]            o_tokens,
    output logic [31:0]            o_stall_cycles
`endif
);
    localparam int CW = FREE_CYCLES > 1 ? $clog2(FREE_CYCLES) : 1;

    state_t                 st, nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   drv_s, drv_q, tok, push, pop, full, empty;
    logic [CW-1:0]          cnt;

    assign drv_s  = sync[SYNC_STAGES-1];
    assign tok    = drv_s && !drv_q;
    assign pop    = o_valid && i_ready && !empty;
    assign o_free = st == FREE;
    assign o_busy = st != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= IDLE;
            sync  <= '0;
            drv_q <= 1'b0;
            cnt   <= '0;
        end else begin
            st    <= nxt;
            sync  <= {sync[SYNC_STAGES-2:0], i_drive};
            drv_q <= drv_s;
            cnt   <= (st == FREE) ? cnt - CW'(1) : CW'(FREE_CYCLES - 1);
        end
    end

    // WAIT_LOW keeps a long drive pulse from being taken as a second token.
    always_comb begin
        nxt  = st;
        push = 1'b0;
        case (st)
            IDLE:       nxt = tok ? CAPTURE : IDLE;
            CAPTURE: begin
                push = !full;
                nxt  = full ? WAIT_SPACE : FREE;
            end
            WAIT_SPACE: begin
                push = !full || pop;
                nxt  = push ? FREE : WAIT_SPACE;
            end
            FREE:       nxt = (cnt == '0) ? WAIT_LOW : FREE;
            WAIT_LOW:   nxt = drv_s ? WAIT_LOW : IDLE;
            default:    nxt = IDLE;
        endcase
    end

    sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(i_data),
        .rdata(o_data),
        .valid(o_valid),
        .full (full),
        .empty(empty),
        .level(o_level)
    );

`ifdef STREAM_SYNC_SINK_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_tokens       <= '0;
            o_stall_cycles <= '0;
        end else begin
            if (push && !(&o_tokens)) o_tokens <= o_tokens + 32'd1;
            if (st == WAIT_SPACE && !(&o_stall_cycles)) o_stall_cycles <= o_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/stream_sync_sink.md
Name: stream_sync_sink

Overview:
- Clocked receiver directly downstream of the two-input mutex merge stage.
- Consumes the merge's drive/free/data bundle and synchronises the drive event into the clk domain.
- Captures the data word into a small FIFO and presents it as a synchronous valid/ready stream.
- Returns a free pulse to the merge only after the word is safely stored, so upstream data is never released early.

Parameters:
- DATA_WIDTH, 128, width of captured data word.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- SYNC_STAGES, 2, flip-flop stages on i_drive; minimum 2.
- FREE_CYCLES, 2, number of clk cycles o_free is held high per token; minimum 1.

Ports:
- clk  input  1  single clock.
- rst  input  1  synchronous, active-high reset.
- i_drive  input  1  drive event from merge stage; asynchronous to clk.
- o_free  output  1  free return to merge stage (its i_freeNext).
- i_data  input  DATA_WIDTH  merged data; stable from drive until free is returned.
- o_valid  output  1  stream word available.
- i_ready  input  1  stream consumer accepts word.
- o_data  output  DATA_WIDTH  FIFO head word.
- o_level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Interface clocking: one clock, clk; reset rst is synchronous and active-high.
- Reset values: o_free=0, o_valid=0, o_data=0, o_level=0, o_busy=0, FSM=IDLE, synchroniser cleared, FIFO pointers 0.
- Reset mid-operation: rst clears all state on the next edge. A pending token is discarded and o_free drops immediately.
- Synchroniser and edge detect:
  - i_drive passes through SYNC_STAGES flops to give drv_s.
  - A rising edge of drv_s (drv_s=1, previous=0) is a token event.
  - A token event is only acted on in IDLE. Edges seen in any other state are ignored; protocol guarantees none occur.
- FSM states:
  - IDLE: on token event -> CAPTURE.
  - CAPTURE: if FIFO not full, write i_data at wr_ptr and go to FREE. If full, go to WAIT_SPACE.
  - WAIT_SPACE: stay until not full, including the same-cycle pop case; then write and go to FREE.
  - FREE: o_free=1 for exactly FREE_CYCLES cycles, counted by a down-counter; then -> WAIT_LOW.
  - WAIT_LOW: o_free=0; wait for drv_s=0, then -> IDLE. This prevents a long drive pulse from being counted twice.
- Latency:
  - Token event to FIFO write: 1 cycle when not full.
  - Write to o_valid: 1 cycle. o_valid is registered from a non-empty FIFO.
  - i_drive rise to o_free rise: SYNC_STAGES+2 cycles minimum.
- FIFO:
  - Pop when o_valid && i_ready. o_data is the head entry, registered.
  - Simultaneous push and pop leaves the level unchanged.
  - Pointers are $clog2(DEPTH)+1 bits and wrap naturally. Full when MSBs differ and the lower bits are equal.
  - A pop while empty is impossible, since o_valid=0.
- Boundary cases:
  - Full with no pop: the FSM holds in WAIT_SPACE indefinitely and o_free stays 0. This is the backpressure path to the merge.
  - DEPTH=2 wrap-around must work.

Optional Feature:
- Macro: STREAM_SYNC_SINK_STATS_EN.
- Defined: adds output o_tokens (32 bits), counting FIFO writes, and output o_stall_cycles (32 bits), counting cycles spent in WAIT_SPACE.
  - Both counters saturate at all-ones and reset to 0.
- Undefined: neither port exists and neither counter exists; all other behaviour is identical.

Decomposition:
- Shared package stream_sink_pkg holds:
  - FSM state enum: IDLE, CAPTURE, WAIT_SPACE, FREE, WAIT_LOW.
  - Localparam helper for pointer width.
- One sub-module is natural: sync_fifo, parameterised by DATA_WIDTH and DEPTH, with ports push, pop, wdata, rdata, full, empty, level.
- The synchroniser and FSM stay in the top module.

Test Plan:
- Single token: i_drive pulses high with i_data=0xA5 and is held until o_free, i_ready=1.
  -> o_free high for 2 cycles starting 4 cycles after the rise; o_valid for 1 cycle with o_data=0xA5.
- Long drive: i_drive held high for 20 cycles, one token.
  -> exactly one FIFO write; o_level never exceeds 1; no second o_free.
- Backpressure: i_ready=0, 5 tokens with data 1..5, DEPTH=4.
  -> tokens 1-4 freed, o_level=4; token 5 stalls in WAIT_SPACE with o_free=0.
  -> raise i_ready: data 1..5 drain in order, and token 5 is freed after the first pop.
- Simultaneous push and pop at level 2.
  -> level stays 2; data order is preserved across pointer wrap, covering 10 tokens.
- Reset during FREE: assert rst in the 1st o_free cycle.
  -> next cycle o_free=0, o_valid=0, o_level=0, FSM in IDLE; the next token is processed normally.
- With STREAM_SYNC_SINK_STATS_EN defined, run the backpressure scenario.
  -> o_tokens=5 and o_stall_cycles equals the cycles spent in WAIT_SPACE.
